// File: rtl/mips_pkg.sv
// Shared decode constants for the single-cycle MIPS core: opcodes, R-type
// funct codes and the ALU operation select.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_ctrl_t;

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file: two combinational read ports, one write port.
// Register 0 is hardwired to zero on read and never written.
module mips_regfile #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [4:0]            ra1,
   input  logic [4:0]            ra2,
   input  logic [4:0]            wa,
   input  logic [DATA_WIDTH-1:0] wd,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2
);

   logic [DATA_WIDTH-1:0] regs [32];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips.sv
// Single-cycle MIPS subset core: decode, ALU and PC sequencing; one
// instruction retires per clock against combinational instruction/data memories.
module mips
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int INST_BUS_WIDTH = 17,
   parameter int DATA_BUS_WIDTH = 17
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_WIDTH-1:0]     imemrd,
   input  logic [DATA_WIDTH-1:0]     dmemrd,
   output logic                      dmemread,
   output logic                      dmemwrite,
   output logic [INST_BUS_WIDTH-1:0] iadr,
   output logic [DATA_BUS_WIDTH-1:0] dadr,
   output logic [DATA_WIDTH-1:0]     dmemwd
);

   logic [DATA_WIDTH-1:0] pc, pc_next, pc_plus4, pc_branch, pc_jump;
   logic [DATA_WIDTH-1:0] imm_ext, rd1, rd2, alu_b, alu_y, wd;
   logic [5:0]            op, funct;
   logic [4:0]            rs, rt, rd, wa;
   logic                  reg_write, alu_src_imm, reg_dst_rd, mem_to_reg;
   logic                  mem_rd, mem_wr, branch, jump;
   alu_ctrl_t             alu_ctrl;

   assign op      = imemrd[31:26];
   assign rs      = imemrd[25:21];
   assign rt      = imemrd[20:16];
   assign rd      = imemrd[15:11];
   assign funct   = imemrd[5:0];
   assign imm_ext = {{(DATA_WIDTH-16){imemrd[15]}}, imemrd[15:0]};

   always_comb begin
      reg_write   = 1'b0;
      alu_src_imm = 1'b0;
      reg_dst_rd  = 1'b0;
      mem_to_reg  = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      alu_ctrl    = ALU_ADD;
      case (op)
         OP_RTYPE: begin
            reg_dst_rd = 1'b1;
            reg_write  = 1'b1;
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: reg_write = 1'b0;
            endcase
         end
         OP_ADDI: begin
            reg_write   = 1'b1;
            alu_src_imm = 1'b1;
         end
         OP_LW: begin
            reg_write   = 1'b1;
            alu_src_imm = 1'b1;
            mem_to_reg  = 1'b1;
            mem_rd      = 1'b1;
         end
         OP_SW: begin
            alu_src_imm = 1'b1;
            mem_wr      = 1'b1;
         end
         OP_BEQ:  branch = 1'b1;
         OP_J:    jump   = 1'b1;
         default: ;
      endcase
   end

   assign alu_b = alu_src_imm ? imm_ext : rd2;

   always_comb begin
      alu_y = '0;
      case (alu_ctrl)
         ALU_ADD: alu_y = rd1 + alu_b;
         ALU_SUB: alu_y = rd1 - alu_b;
         ALU_AND: alu_y = rd1 & alu_b;
         ALU_OR:  alu_y = rd1 | alu_b;
         ALU_SLT: alu_y = ($signed(rd1) < $signed(alu_b)) ? DATA_WIDTH'(1) : '0;
         default: alu_y = '0;
      endcase
   end

   assign pc_plus4  = pc + DATA_WIDTH'(4);
   assign pc_branch = pc_plus4 + (imm_ext << 2);
   assign pc_jump   = {pc_plus4[DATA_WIDTH-1:28], imemrd[25:0], 2'b00};

   always_comb begin
      pc_next = pc_plus4;
      if (jump)                     pc_next = pc_jump;
      else if (branch && rd1 == rd2) pc_next = pc_branch;
   end

   always_ff @(posedge clk) begin
      if (reset) pc <= '0;
      else       pc <= pc_next;
   end

   assign wa = reg_dst_rd ? rd : rt;
   assign wd = mem_to_reg ? dmemrd : alu_y;

   mips_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (reg_write & ~reset),
      .ra1   (rs),
      .ra2   (rt),
      .wa    (wa),
      .wd    (wd),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   // Strobes are gated so nothing touches memory while reset is held.
   assign dmemread  = mem_rd & ~reset;
   assign dmemwrite = mem_wr & ~reset;
   assign iadr      = pc[INST_BUS_WIDTH-1:0];
   assign dadr      = alu_y[DATA_BUS_WIDTH-1:0];
   assign dmemwd    = rd2;

endmodule

// File: tb/tb_mips.sv
// Bench for mips: instruction-set-level reference model run in lockstep with
// the core on random and directed programs, plus fixed-value store/fetch checks.
module tb_mips;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imemrd, dmemrd, dmemwd;
   logic        dmemread, dmemwrite;
   logic [16:0] iadr, dadr;

   logic [31:0] rom [32768];
   logic [31:0] ram [32768] = '{default: '0};
   logic        pre_we = 1'b0;
   logic [14:0] pre_idx = '0;
   logic [31:0] pre_data = '0;

   always #5 clk = ~clk;

   mips #(.DATA_WIDTH(32), .INST_BUS_WIDTH(17), .DATA_BUS_WIDTH(17)) dut (
      .clk       (clk),
      .reset     (reset),
      .imemrd    (imemrd),
      .dmemrd    (dmemrd),
      .dmemread  (dmemread),
      .dmemwrite (dmemwrite),
      .iadr      (iadr),
      .dadr      (dadr),
      .dmemwd    (dmemwd)
   );

   assign imemrd = rom[iadr[16:2]];
   assign dmemrd = ram[dadr[16:2]];

   always @(posedge clk) begin
      if (pre_we)         ram[pre_idx] <= pre_data;
      else if (dmemwrite) ram[dadr[16:2]] <= dmemwd;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Architectural reference state
   logic [31:0] m_reg [32];
   logic [31:0] m_pc;
   logic [31:0] m_mem [int];

   logic [31:0] tr_iadr [$];
   logic [31:0] tr_dadr [$];
   logic [31:0] tr_wd [$];
   logic        tr_we [$];
   logic        tr_rd [$];

   function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] j_ins(logic [25:0] target);
      return {6'h02, target};
   endfunction

   task automatic model_cycle();
      logic [31:0] ins, a, b, simm, ea, pc4, npc, v;
      logic [5:0]  op, fn;
      int          rs, rt, rd, key;
      ins  = rom[m_pc[16:2]];
      op   = ins[31:26];
      fn   = ins[5:0];
      rs   = int'(ins[25:21]);
      rt   = int'(ins[20:16]);
      rd   = int'(ins[15:11]);
      simm = {{16{ins[15]}}, ins[15:0]};
      a    = m_reg[rs];
      b    = m_reg[rt];
      ea   = a + simm;
      key  = int'(ea[16:2]);
      pc4  = m_pc + 32'd4;
      npc  = pc4;

      check("iadr", {15'd0, iadr}, {15'd0, m_pc[16:0]});
      check("dmemread", 32'(dmemread), 32'(op == 6'h23));
      check("dmemwrite", 32'(dmemwrite), 32'(op == 6'h2B));
      if (op == 6'h23 || op == 6'h2B) check("dadr", {15'd0, dadr}, {15'd0, ea[16:0]});
      if (op == 6'h2B) check("dmemwd", dmemwd, b);
      tr_iadr.push_back({15'd0, iadr});
      tr_dadr.push_back({15'd0, dadr});
      tr_wd.push_back(dmemwd);
      tr_we.push_back(dmemwrite);
      tr_rd.push_back(dmemread);

      case (op)
         6'h00: begin
            if (fn == 6'h20)      v = a + b;
            else if (fn == 6'h22) v = a - b;
            else if (fn == 6'h24) v = a & b;
            else if (fn == 6'h25) v = a | b;
            else if (fn == 6'h2A) v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            if ((fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) && rd != 0)
               m_reg[rd] = v;
         end
         6'h08: if (rt != 0) m_reg[rt] = ea;
         6'h23: if (rt != 0) m_reg[rt] = m_mem.exists(key) ? m_mem[key] : 32'd0;
         6'h2B: m_mem[key] = b;
         6'h04: if (a == b) npc = pc4 + (simm << 2);
         6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic begin_prog();
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 1024; i++) rom[i] = 32'd0;
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      tr_iadr.delete(); tr_dadr.delete(); tr_wd.delete(); tr_we.delete(); tr_rd.delete();
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      pre_idx  = 15'(idx);
      pre_data = val;
      pre_we   = 1'b1;
      @(negedge clk);
      pre_we   = 1'b0;
      m_mem[idx] = val;
   endtask

   task automatic run_prog(input int ncyc);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("reset_iadr", {15'd0, iadr}, 32'd0);
         check("reset_dmemwrite", 32'(dmemwrite), 32'd0);
         check("reset_dmemread", 32'(dmemread), 32'd0);
      end
      reset = 1'b0;
      m_pc  = 32'd0;
      for (int c = 0; c < ncyc; c++) begin
         #1;
         model_cycle();
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] rand_ins();
      logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      int k;
      k = int'($urandom_range(0, 11));
      case (k)
         0, 1, 2, 3: return r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                  fns[$urandom_range(0, 4)]);
         4, 5:       return i_ins(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
         6:          return i_ins(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
         7:          return i_ins(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
         8:          return i_ins(6'h04, $urandom_range(0, 3), $urandom_range(0, 3),
                                  16'(int'($urandom_range(0, 16)) - 8));
         9:          return j_ins(26'($urandom_range(0, 127)));
         10:         return r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                  6'($urandom));
         default:    return $urandom;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 32768; i++) rom[i] = 32'd0;

      // Random programs: seed $1..$7, then a random mix including illegal encodings
      for (int p = 0; p < 3; p++) begin
         begin_prog();
         for (int r = 1; r < 8; r++) rom[r-1] = i_ins(6'h08, 0, r, 16'($urandom));
         for (int i = 7; i < 128; i++) rom[i] = rand_ins();
         for (int w = 0; w < 8; w++) preload(w, $urandom);
         run_prog(500);
      end

      // addi $1,$0,210; sw $1,255($0)
      begin_prog();
      rom[0] = i_ins(6'h08, 0, 1, 16'd210);
      rom[1] = i_ins(6'h2B, 0, 1, 16'd255);
      run_prog(6);
      check("p1_we", 32'(tr_we[1]), 32'd1);
      check("p1_dadr", tr_dadr[1], 32'd255);
      check("p1_wd", tr_wd[1], 32'd210);

      // sub / slt results stored
      begin_prog();
      rom[0] = i_ins(6'h08, 0, 2, 16'd7);
      rom[1] = i_ins(6'h08, 0, 3, 16'd3);
      rom[2] = r_ins(2, 3, 4, 6'h22);
      rom[3] = r_ins(3, 2, 5, 6'h2A);
      rom[4] = i_ins(6'h2B, 0, 4, 16'd0);
      rom[5] = i_ins(6'h2B, 0, 5, 16'd4);
      run_prog(8);
      check("p2_sub_wd", tr_wd[4], 32'd4);
      check("p2_slt_wd", tr_wd[5], 32'd1);

      // lw from preloaded word, then store it back
      begin_prog();
      preload(2, 32'h1234);
      rom[0] = i_ins(6'h23, 0, 6, 16'd8);
      rom[1] = i_ins(6'h2B, 0, 6, 16'd12);
      run_prog(6);
      check("p3_lw_rd", 32'(tr_rd[0]), 32'd1);
      check("p3_lw_we", 32'(tr_we[0]), 32'd0);
      check("p3_wd", tr_wd[1], 32'h1234);
      check("p3_dadr", tr_dadr[1], 32'd12);

      // beq skips addi, j lands on sw; $7 must still be the reset value
      begin_prog();
      rom[0] = i_ins(6'h04, 0, 0, 16'd1);
      rom[1] = i_ins(6'h08, 0, 7, 16'd1);
      rom[2] = j_ins(26'd5);
      rom[3] = i_ins(6'h08, 0, 7, 16'd2);
      rom[4] = i_ins(6'h08, 0, 7, 16'd2);
      rom[5] = i_ins(6'h2B, 0, 7, 16'd0);
      run_prog(6);
      check("p4_iadr_branch", tr_iadr[1], 32'd8);
      check("p4_iadr_jump", tr_iadr[2], 32'd20);
      check("p4_we", 32'(tr_we[2]), 32'd1);
      check("p4_wd", tr_wd[2], 32'd0);

      // write to $0 is discarded
      begin_prog();
      rom[0] = i_ins(6'h08, 0, 0, 16'd9);
      rom[1] = i_ins(6'h2B, 0, 0, 16'd0);
      run_prog(4);
      check("p5_wd", tr_wd[1], 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mips.md
MIPS -- requirements
Module: mips

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath, register and instruction width.
REQ-002 SHALL have parameter INST_BUS_WIDTH, default 17, instruction byte-address width.
REQ-003 SHALL have parameter DATA_BUS_WIDTH, default 17, data byte-address width.
REQ-004 SHALL declare ports in this positional order: clk, reset, imemrd, dmemrd, dmemread, dmemwrite, iadr, dadr, dmemwd.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 imemrd  input  DATA_WIDTH  instruction word at iadr, from a combinational-read ROM.
REQ-008 dmemrd  input  DATA_WIDTH  data word at dadr, from a combinational-read RAM.
REQ-009 dmemread  output  1  high while the current instruction is lw.
REQ-010 dmemwrite  output  1  high while the current instruction is sw; the RAM writes on the next rising edge.
REQ-011 iadr  output  INST_BUS_WIDTH  low bits of the PC (byte address).
REQ-012 dadr  output  DATA_BUS_WIDTH  low bits of the effective address (rs + sign-extended imm).
REQ-013 dmemwd  output  DATA_WIDTH  store data, taken from register rt.

Function
REQ-014 SHALL be single-cycle: one instruction is fetched, executed and retired per clock; PC, register file and data-memory write all update on the same rising edge.
REQ-015 SHALL implement R-type add, sub, and, or, slt (opcode 0x00, funct 0x20/0x22/0x24/0x25/0x2A), plus addi 0x08, lw 0x23, sw 0x2B, beq 0x04 and j 0x02.
REQ-016 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; slt SHALL be a signed compare producing 1 or 0.
REQ-017 addi, lw and sw SHALL sign-extend imm[15:0].
REQ-018 Next PC SHALL be PC+4 by default.
REQ-019 beq taken SHALL set PC to PC+4+(sign-extended imm<<2).
REQ-020 j SHALL set PC to {PC+4[31:28], target, 2'b00}.
REQ-021 Writes to register 0 SHALL be ignored; register 0 SHALL always read 0.
REQ-022 dadr SHALL be the unmodified low bits of the effective address; no alignment check or trap.
REQ-023 lw SHALL write dmemrd to rt on the rising edge ending its cycle.
REQ-024 Unrecognised opcodes or functs SHALL execute as NOP: no register write, no memory strobe, PC+4.
REQ-025 dmemread and dmemwrite SHALL never both be high.
REQ-026 Register reads SHALL be combinational; a write is visible to the next instruction.

Reset
REQ-027 While reset is high, each rising edge SHALL set PC to 0 and clear all 32 registers.
REQ-028 While reset is high, dmemwrite and dmemread SHALL be forced to 0 and no register write SHALL occur.
REQ-029 The first instruction after reset falls SHALL be fetched from iadr 0.

Structure
REQ-030 A shared package SHALL hold the opcode and funct constants and the ALU-control encoding.
REQ-031 The register file SHALL be one sub-module, mips_regfile: 32 x DATA_WIDTH, 2 read ports, 1 write port.
REQ-032 Control decode, ALU and PC logic SHALL reside in mips.

Verification
REQ-033 Hold reset for 2 cycles: iadr=0 and dmemwrite=0 throughout.
REQ-034 Run addi $1,$0,210; sw $1,255($0): in the second cycle dmemwrite=1, dadr=255, dmemwd=210.
REQ-035 Run addi $2,$0,7; addi $3,$0,3; sub $4,$2,$3; slt $5,$3,$2; sw $4,0($0); sw $5,4($0): the stores show dmemwd 4 then 1.
REQ-036 Preload RAM word at 8 with 0x1234, then run lw $6,8($0); sw $6,12($0): dmemread=1 in the lw cycle and the store shows dmemwd=0x1234, dadr=12.
REQ-037 Run beq $0,$0,+1 over addi $7,$0,1; j to a sw $7,0($0): the store shows dmemwd=0 and iadr follows the branch and jump targets.
REQ-038 Run addi $0,$0,9; sw $0,0($0): the store shows dmemwd=0.
